// File: rtl/regfile_mp.sv
// Multi-port register file: one write port, two read ports, per-register written mask,
// optional write-to-read bypass and optional registered read stage.
module regfile_mp #(
  parameter  int unsigned WIDTH        = 16,
  parameter  int unsigned DEPTH        = 8,
  parameter  int unsigned BYPASS       = 1,
  parameter  int unsigned READ_LATENCY = 0,
  localparam int unsigned AW           = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    writenum,
  input  logic             write,
  input  logic             clear,
  input  logic [AW-1:0]    readnum_a,
  input  logic [AW-1:0]    readnum_b,
  input  logic             read_en,
  output logic [WIDTH-1:0] data_out_a,
  output logic [WIDTH-1:0] data_out_b,
  output logic             valid_a,
  output logic             valid_b,
  output logic [DEPTH-1:0] written_mask
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] mask_q;
  logic [DEPTH-1:0] mask_d;

  logic             wr_ok;
  logic             rd_ok_a;
  logic             rd_ok_b;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             rd_valid_a;
  logic             rd_valid_b;

  assign wr_ok   = write && ({1'b0, writenum}  < DEPTH_W);
  assign rd_ok_a = ({1'b0, readnum_a} < DEPTH_W);
  assign rd_ok_b = ({1'b0, readnum_b} < DEPTH_W);

  // Next storage state: clear wins over a same-cycle write.
  always_comb begin
    regs_d = regs_q;
    mask_d = mask_q;
    if (clear) begin
      for (int i = 0; i < int'(DEPTH); i++) regs_d[i] = '0;
      mask_d = '0;
    end else if (wr_ok) begin
      regs_d[writenum] = data_in;
      mask_d[writenum] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) regs_q[i] <= '0;
      mask_q <= '0;
    end else begin
      regs_q <= regs_d;
      mask_q <= mask_d;
    end
  end

  assign written_mask = mask_q;

  // Port A read value, including bypass of the in-flight write or clear.
  always_comb begin
    rd_data_a  = '0;
    rd_valid_a = 1'b0;
    if (!reset_n || !rd_ok_a) begin
      rd_data_a  = '0;
      rd_valid_a = 1'b0;
    end else if ((BYPASS != 0) && write && !clear && (readnum_a == writenum)) begin
      rd_data_a  = data_in;
      rd_valid_a = 1'b1;
    end else if ((BYPASS != 0) && clear) begin
      rd_data_a  = '0;
      rd_valid_a = 1'b0;
    end else begin
      rd_data_a  = regs_q[readnum_a];
      rd_valid_a = mask_q[readnum_a];
    end
  end

  always_comb begin
    rd_data_b  = '0;
    rd_valid_b = 1'b0;
    if (!reset_n || !rd_ok_b) begin
      rd_data_b  = '0;
      rd_valid_b = 1'b0;
    end else if ((BYPASS != 0) && write && !clear && (readnum_b == writenum)) begin
      rd_data_b  = data_in;
      rd_valid_b = 1'b1;
    end else if ((BYPASS != 0) && clear) begin
      rd_data_b  = '0;
      rd_valid_b = 1'b0;
    end else begin
      rd_data_b  = regs_q[readnum_b];
      rd_valid_b = mask_q[readnum_b];
    end
  end

  if (READ_LATENCY == 0) begin : g_comb_read
    logic unused_read_en;
    assign unused_read_en = read_en;
    assign data_out_a = rd_data_a;
    assign data_out_b = rd_data_b;
    assign valid_a    = rd_valid_a;
    assign valid_b    = rd_valid_b;
  end else begin : g_reg_read
    logic [WIDTH-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
    logic             valid_a_q, valid_a_d, valid_b_q, valid_b_d;

    // Output stage captures only on read_en, otherwise holds.
    always_comb begin
      data_a_d  = data_a_q;
      data_b_d  = data_b_q;
      valid_a_d = valid_a_q;
      valid_b_d = valid_b_q;
      if (read_en) begin
        data_a_d  = rd_data_a;
        data_b_d  = rd_data_b;
        valid_a_d = rd_valid_a;
        valid_b_d = rd_valid_b;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        data_a_q  <= '0;
        data_b_q  <= '0;
        valid_a_q <= 1'b0;
        valid_b_q <= 1'b0;
      end else begin
        data_a_q  <= data_a_d;
        data_b_q  <= data_b_d;
        valid_a_q <= valid_a_d;
        valid_b_q <= valid_b_d;
      end
    end

    assign data_out_a = data_a_q;
    assign data_out_b = data_b_q;
    assign valid_a    = valid_a_q;
    assign valid_b    = valid_b_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: four configurations share one stimulus stream,
// expected values queued at drive time and popped when outputs are sampled.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] data_in;
  logic [2:0]  writenum;
  logic        write;
  logic        clear;
  logic [2:0]  readnum_a;
  logic [2:0]  readnum_b;
  logic        read_en;

  logic [15:0] byp_da, byp_db, nob_da, nob_db, rl_da, rl_db, d6_da, d6_db;
  logic        byp_va, byp_vb, nob_va, nob_vb, rl_va, rl_vb, d6_va, d6_vb;
  logic [7:0]  byp_mask, nob_mask, rl_mask;
  logic [5:0]  d6_mask;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  regfile_mp #(.WIDTH(16), .DEPTH(8), .BYPASS(1), .READ_LATENCY(0)) u_byp (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .writenum(writenum), .write(write),
    .clear(clear), .readnum_a(readnum_a), .readnum_b(readnum_b), .read_en(read_en),
    .data_out_a(byp_da), .data_out_b(byp_db), .valid_a(byp_va), .valid_b(byp_vb),
    .written_mask(byp_mask));

  regfile_mp #(.WIDTH(16), .DEPTH(8), .BYPASS(0), .READ_LATENCY(0)) u_nob (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .writenum(writenum), .write(write),
    .clear(clear), .readnum_a(readnum_a), .readnum_b(readnum_b), .read_en(read_en),
    .data_out_a(nob_da), .data_out_b(nob_db), .valid_a(nob_va), .valid_b(nob_vb),
    .written_mask(nob_mask));

  regfile_mp #(.WIDTH(16), .DEPTH(8), .BYPASS(1), .READ_LATENCY(1)) u_rl1 (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .writenum(writenum), .write(write),
    .clear(clear), .readnum_a(readnum_a), .readnum_b(readnum_b), .read_en(read_en),
    .data_out_a(rl_da), .data_out_b(rl_db), .valid_a(rl_va), .valid_b(rl_vb),
    .written_mask(rl_mask));

  regfile_mp #(.WIDTH(16), .DEPTH(6), .BYPASS(1), .READ_LATENCY(0)) u_d6 (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .writenum(writenum), .write(write),
    .clear(clear), .readnum_a(readnum_a), .readnum_b(readnum_b), .read_en(read_en),
    .data_out_a(d6_da), .data_out_b(d6_db), .valid_a(d6_va), .valid_b(d6_vb),
    .written_mask(d6_mask));

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed=%0d but no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, obs, e);
      end
    end
  endtask

  task automatic wr(input logic [2:0] idx, input logic [15:0] d);
    @(negedge clk);
    write = 1'b1; writenum = idx; data_in = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; data_in = '0; writenum = '0; write = 1'b0; clear = 1'b0;
    readnum_a = '0; readnum_b = '0; read_en = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Write R1 then pulse reset mid-cycle: outputs drop immediately.
    @(negedge clk);
    write = 1'b1; writenum = 3'd1; data_in = 16'd5; readnum_a = 3'd1;
    push(32'h02); push(32'd5);
    @(posedge clk); #1;
    chk("mask_before_rst", 32'(byp_mask));
    chk("rd_before_rst", 32'(byp_da));
    write = 1'b0;
    push(32'h00); push(32'd0); push(32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mask", 32'(byp_mask));
    chk("rst_data_a", 32'(byp_da));
    chk("rst_valid_a", 32'(byp_va));
    @(negedge clk);
    reset_n = 1'b1;

    // Two writes then dual-port read.
    wr(3'd2, 16'd42);
    wr(3'd5, 16'd25);
    readnum_a = 3'd5; readnum_b = 3'd2;
    push(32'd25); push(32'd42); push(32'd1); push(32'd1); push(32'h24);
    push(32'd25); push(32'd42); push(32'h24);
    #1;
    chk("rd_a", 32'(byp_da));
    chk("rd_b", 32'(byp_db));
    chk("valid_a", 32'(byp_va));
    chk("valid_b", 32'(byp_vb));
    chk("mask_24", 32'(byp_mask));
    chk("nob_rd_a", 32'(nob_da));
    chk("nob_rd_b", 32'(nob_db));
    chk("d6_mask_24", 32'(d6_mask));

    // Same-cycle write/read of R7 with and without bypass.
    @(negedge clk);
    write = 1'b1; writenum = 3'd7; data_in = 16'd400; readnum_a = 3'd7;
    push(32'd400); push(32'd1); push(32'd0); push(32'd0); push(32'd0); push(32'd0);
    #1;
    chk("byp_pre_edge", 32'(byp_da));
    chk("byp_pre_valid", 32'(byp_va));
    chk("nob_pre_edge", 32'(nob_da));
    chk("nob_pre_valid", 32'(nob_va));
    chk("d6_oor_data", 32'(d6_da));
    chk("d6_oor_valid", 32'(d6_va));
    push(32'd400); push(32'd1); push(32'h24);
    @(posedge clk); #1;
    chk("nob_post_edge", 32'(nob_da));
    chk("nob_post_valid", 32'(nob_va));
    chk("d6_mask_w7", 32'(d6_mask));

    // Out-of-range write index 6 on the 6-deep instance.
    @(negedge clk);
    write = 1'b1; writenum = 3'd6; data_in = 16'd77; readnum_b = 3'd6;
    push(32'd0); push(32'd0); push(32'h24); push(32'hE4);
    #1;
    chk("d6_rd6_data", 32'(d6_db));
    chk("d6_rd6_valid", 32'(d6_vb));
    @(posedge clk); #1;
    chk("d6_mask_w6", 32'(d6_mask));
    chk("byp_mask_w6", 32'(byp_mask));
    @(negedge clk);
    write = 1'b0;

    // Clear beats a simultaneous write of R3.
    clear = 1'b1; write = 1'b1; writenum = 3'd3; data_in = 16'd9; readnum_a = 3'd3;
    readnum_b = 3'd2;
    push(32'd0); push(32'd0);
    #1;
    chk("clr_byp_data", 32'(byp_da));
    chk("clr_byp_valid", 32'(byp_va));
    @(negedge clk);
    clear = 1'b0; write = 1'b0;
    push(32'd0); push(32'd0); push(32'h00); push(32'd0); push(32'h00); push(32'h00);
    #1;
    chk("clr_r3", 32'(byp_da));
    chk("clr_r3_valid", 32'(byp_va));
    chk("clr_mask", 32'(byp_mask));
    chk("clr_r2", 32'(nob_db));
    chk("clr_nob_mask", 32'(nob_mask));
    chk("clr_d6_mask", 32'(d6_mask));

    // Registered read path: capture on read_en, hold otherwise.
    wr(3'd2, 16'd42);
    wr(3'd5, 16'd25);
    readnum_a = 3'd2; read_en = 1'b1;
    push(32'd0); push(32'd42); push(32'd1);
    #1;
    chk("rl_pre_capture", 32'(rl_da));
    @(posedge clk); #1;
    chk("rl_capture_42", 32'(rl_da));
    chk("rl_capture_valid", 32'(rl_va));
    @(negedge clk);
    read_en = 1'b0; readnum_a = 3'd5;
    push(32'd42);
    @(posedge clk); #1;
    chk("rl_hold_42", 32'(rl_da));
    @(negedge clk);
    read_en = 1'b1;
    push(32'd25);
    @(posedge clk); #1;
    chk("rl_capture_25", 32'(rl_da));

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: observed=%0d leftover expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
